// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: latches rising-edge interrupt events from N_SRC peripherals,
// presents one at a time to the CPU in round-robin order, and exposes a
// four-register bus block (PENDING, MASK, STATUS, CLEAR) at BASE_ADDR.
module interrupt_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
    input  logic             CLK,
    input  logic             RESETN,
    inout  wire  [7:0]       BUS_DATA,
    input  logic [7:0]       BUS_ADDR,
    input  logic             BUS_WE,
    input  logic [N_SRC-1:0] IRQ_IN,
    output logic [N_SRC-1:0] IRQ_ACK_OUT,
    output logic             CPU_INT,
    input  logic             CPU_INT_ACK,
    output logic [2:0]       CPU_INT_ID
);

    typedef enum logic [1:0] {IDLE, PRESENT, ACK, GUARD} state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [N_SRC-1:0] armed_q, armed_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       id_q, id_d;
    logic             rd_en_q, rd_en_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic [7:0]       addr_off;
    logic             wr_mask, wr_clr;
    logic [N_SRC-1:0] irq_set, sw_clr, ack_clr, pend_noack, id_oh, req, req_rot;
    logic [2:0]       winner;
    logic             found;
    int unsigned      idx;

    assign addr_off = BUS_ADDR - BASE_ADDR;
    assign id_oh    = {{(N_SRC-1){1'b0}}, 1'b1} << id_q;
    assign req      = pending_q & mask_q;

    if (N_SRC < 8) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^BUS_DATA[7:N_SRC];
    end

    // Edge detection, register writes and PENDING set/clear (set wins)
    always_comb begin
        // armed_q blocks events from a level already high when reset released;
        // a source must be seen low once before its edges count.
        irq_set    = IRQ_IN & ~irq_prev_q & armed_q;
        irq_prev_d = IRQ_IN;
        armed_d    = armed_q | ~IRQ_IN;
        wr_mask    = BUS_WE && (addr_off == 8'd1);
        wr_clr     = BUS_WE && (addr_off == 8'd3);
        mask_d     = wr_mask ? BUS_DATA[N_SRC-1:0] : mask_q;
        sw_clr     = wr_clr ? BUS_DATA[N_SRC-1:0] : '0;
        ack_clr    = (state_q == PRESENT && CPU_INT_ACK) ? id_oh : '0;
        pend_noack = (pending_q & ~sw_clr) | irq_set;
        pending_d  = (pending_q & ~(sw_clr | ack_clr)) | irq_set;
    end

    // Round-robin search starting one past the last acknowledged source
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        req_rot = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx     = (32'(rr_ptr_q) + k) % N_SRC;
            req_rot = req >> idx;
            if (!found && req_rot[0]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    // FSM next state, presented ID and round-robin pointer
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = winner;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Withdrawal looks at the values being written this edge so a
                // mask or clear drops CPU_INT on the very next cycle.
                if (CPU_INT_ACK) begin
                    state_d  = ACK;
                    rr_ptr_d = id_q;
                end else if ((pend_noack & mask_d & id_oh) == '0) begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered bus read data, one cycle after the addressed edge
    always_comb begin
        rd_en_d   = !BUS_WE && (addr_off < 8'd4);
        rd_data_d = '0;
        case (addr_off[1:0])
            2'd0:    rd_data_d = 8'(pending_q);
            2'd1:    rd_data_d = 8'(mask_q);
            2'd2:    rd_data_d = {(state_q == PRESENT), 4'b0000, id_q};
            default: rd_data_d = '0;
        endcase
    end

    // CPU-side and acknowledge outputs decoded from state
    always_comb begin
        CPU_INT     = (state_q == PRESENT);
        CPU_INT_ID  = id_q;
        IRQ_ACK_OUT = (state_q == ACK) ? id_oh : '0;
    end

    assign BUS_DATA = rd_en_q ? rd_data_q : 'z;

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            armed_q    <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            rr_ptr_q   <= 3'(N_SRC - 1);
            id_q       <= '0;
            rd_en_q    <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            rd_en_q    <= rd_en_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of peripheral interrupt sources; index 0 is the mouse; legal range 2..8.
REQ-002 Parameter BASE_ADDR, default 8'hF0: bus base address of the 4-register block (BASE_ADDR+0..+3).
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RESETN  input  1  reset, asynchronous, active-low.
REQ-005 BUS_DATA  inout  8  shared data bus; driven only during a decoded read, else high-Z.
REQ-006 BUS_ADDR  input  8  shared address bus.
REQ-007 BUS_WE  input  1  1 = write cycle, 0 = read cycle.
REQ-008 IRQ_IN  input  N_SRC  per-source interrupt requests (level, synchronous to CLK).
REQ-009 IRQ_ACK_OUT  output  N_SRC  per-source acknowledge, one-cycle pulse.
REQ-010 CPU_INT  output  1  interrupt request to processor.
REQ-011 CPU_INT_ACK  input  1  processor acknowledge, one-cycle pulse.
REQ-012 CPU_INT_ID  output  3  index of the source being presented to the processor.

Function
REQ-013 Registers: +0 PENDING (R), +1 MASK (R/W, 1 = enabled), +2 STATUS (R: bit7 = CPU_INT, bits2:0 = CPU_INT_ID), +3 CLEAR (W: write-1-to-clear PENDING bits); unused upper bits read 0.
REQ-014 Rising edge of IRQ_IN[i] (registered previous value 0, current 1) sets PENDING[i] on the next clock edge; PENDING captures events whether or not MASK[i] is set.
REQ-015 Level held high sets PENDING[i] once only; a new event requires IRQ_IN[i] to return low.
REQ-016 Same-cycle set and clear of PENDING[i] (via CLEAR write or acknowledge): set wins.
REQ-017 FSM states IDLE, PRESENT, ACK, GUARD; reset state IDLE.
REQ-018 IDLE: if (PENDING & MASK) != 0, select a winner by round-robin starting at index RR_PTR+1 (wrapping at N_SRC-1 -> 0), latch it into CPU_INT_ID, go to PRESENT.
REQ-019 PRESENT: CPU_INT = 1; CPU_INT_ID stable.
REQ-020 PRESENT with CPU_INT_ACK = 1 -> ACK; PENDING[CPU_INT_ID] is cleared and RR_PTR is set to CPU_INT_ID on that edge.
REQ-021 PRESENT with MASK[CPU_INT_ID] = 0 or PENDING[CPU_INT_ID] = 0 (cleared by software), and no CPU_INT_ACK -> IDLE; no IRQ_ACK_OUT pulse; RR_PTR unchanged.
REQ-022 CPU_INT_ACK and a mask or clear on the same cycle: acknowledge wins (REQ-020).
REQ-023 ACK: IRQ_ACK_OUT[CPU_INT_ID] = 1 for exactly this one cycle, all other bits 0; CPU_INT = 0; unconditional -> GUARD.
REQ-024 GUARD: CPU_INT = 0 for one cycle, then -> IDLE; this guarantees CPU_INT is low for at least 2 cycles between presentations.
REQ-025 CPU_INT_ACK outside PRESENT is ignored.
REQ-026 Bus write: BUS_WE = 1 and BUS_ADDR = BASE_ADDR+1 loads MASK[N_SRC-1:0] from BUS_DATA on that edge; BASE_ADDR+3 clears the PENDING bits written as 1; writes to +0 and +2 are ignored.
REQ-027 Bus read: BUS_WE = 0 and BUS_ADDR in BASE_ADDR..+3 drives BUS_DATA with the register value from the next cycle (1-cycle registered latency); any other address or a write cycle gives high-Z the next cycle.
REQ-028 Read of PENDING returns the value as of the addressed edge; same-cycle events appear on the following read.
REQ-029 Latency: IRQ_IN edge at cycle n -> PENDING set at n+1 -> CPU_INT high at n+2, with IDLE and the source unmasked and winning.

Reset
REQ-030 RESETN low asynchronously forces: state IDLE, PENDING = 0, MASK = all 1, RR_PTR = N_SRC-1 (so index 0 has first priority), CPU_INT = 0, CPU_INT_ID = 0, IRQ_ACK_OUT = 0, BUS_DATA high-Z, edge-detect registers = 0.
REQ-031 Reset during PRESENT or ACK aborts without an IRQ_ACK_OUT pulse; after release, a still-high IRQ_IN[i] does not create an event until it goes low then high again.

Verification
REQ-032 Single source: IRQ_IN[0] rises at cycle 10 -> PENDING = 8'h01 at 11, CPU_INT = 1 with ID = 0 at 12; CPU_INT_ACK at 15 -> IRQ_ACK_OUT = 4'b0001 at 16, CPU_INT = 0, PENDING = 0.
REQ-033 Round-robin: IRQ_IN[0] and [2] rise together, each acknowledged -> served order 0, 2; both re-raised -> served order 0, 2 again, with no source served twice while another is pending.
REQ-034 Mask: write 8'h0E to BASE_ADDR+1, raise IRQ_IN[0] -> PENDING = 8'h01, CPU_INT stays 0; write 8'h0F -> CPU_INT = 1 with ID = 0 within 2 cycles.
REQ-035 Software clear during PRESENT: source 1 presented, write 8'h02 to BASE_ADDR+3 -> CPU_INT = 0 next cycle, no IRQ_ACK_OUT pulse, state IDLE.
REQ-036 Bus: read BASE_ADDR+2 while presenting source 3 -> BUS_DATA = 8'h83 the next cycle; read 8'hA0 -> BUS_DATA high-Z from this block.
REQ-037 Reset mid-PRESENT with IRQ_IN[1] held high -> all outputs reset, and no new interrupt until IRQ_IN[1] toggles low then high.
